// File: rtl/cpri_chip_sync_unpack.sv
// CPRI chip-frame sync: hunt/check/lock flywheel on sop_i, strips the
// per-chip header and emits the payload as a 512-bit stream with a chip index.
module cpri_chip_sync_unpack #(
    parameter int CHIP_LEN   = 96,
    parameter int HDR_LEN    = 4,
    parameter int CHIP_COUNT = 36,
    parameter int DAT_DW     = 64,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_DW     = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sop_i,
    input  logic [DAT_DW-1:0]                    dat0_i,
    input  logic [DAT_DW-1:0]                    dat1_i,
    input  logic [DAT_DW-1:0]                    dat2_i,
    input  logic [DAT_DW-1:0]                    dat3_i,
    input  logic [DAT_DW-1:0]                    dat4_i,
    input  logic [DAT_DW-1:0]                    dat5_i,
    input  logic [DAT_DW-1:0]                    dat6_i,
    input  logic [DAT_DW-1:0]                    dat7_i,
    input  logic                                 err_clr_i,
    output logic                                 vld_o,
    output logic                                 sop_o,
    output logic                                 eop_o,
    output logic [8*DAT_DW-1:0]                  dat_o,
    output logic [$clog2(CHIP_COUNT)-1:0]        chip_idx_o,
    output logic                                 lock_o,
    output logic [ERR_DW-1:0]                    err_cnt_o
);

    localparam int PW = $clog2(CHIP_LEN);
    localparam int CW = $clog2(CHIP_COUNT);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCK
    } state_t;

    state_t          state;
    logic [PW-1:0]   pos;
    logic [GW-1:0]   good_cnt;
    logic [MW-1:0]   miss_cnt;
    logic            bad_flag;
    logic [CW-1:0]   chip_idx;

    logic            bnd;
    logic [PW-1:0]   pos_inc;
    logic [CW-1:0]   chip_inc;
    logic            exit_due;
    logic            miss_ev;
    logic            payload;

    assign bnd      = (pos == '0);
    assign pos_inc  = (pos == PW'(CHIP_LEN - 1)) ? '0 : pos + 1'b1;
    assign chip_inc = (chip_idx == CW'(CHIP_COUNT - 1)) ? '0 : chip_idx + 1'b1;
    assign exit_due = (miss_cnt == MW'(UNLOCK_CNT));
    assign miss_ev  = (state == LOCK) && bnd && !exit_due && (!sop_i || bad_flag);
    assign payload  = (state == LOCK) && (pos >= PW'(HDR_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            pos      <= '0;
            good_cnt <= '0;
            miss_cnt <= '0;
            bad_flag <= 1'b0;
            chip_idx <= '0;
            lock_o   <= 1'b0;
        end else begin
            unique case (state)
                HUNT: begin
                    if (sop_i) begin
                        state    <= CHECK;
                        pos      <= PW'(1);
                        good_cnt <= '0;
                    end
                end
                CHECK: begin
                    if (bnd) begin
                        if (sop_i) begin
                            pos <= pos_inc;
                            if (good_cnt == GW'(LOCK_CNT - 1)) begin
                                state    <= LOCK;
                                lock_o   <= 1'b1;
                                chip_idx <= '0;
                                miss_cnt <= '0;
                                bad_flag <= 1'b0;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else begin
                            state <= HUNT;
                            pos   <= '0;
                        end
                    end else if (sop_i) begin
                        pos      <= PW'(1);
                        good_cnt <= '0;
                    end else begin
                        pos <= pos_inc;
                    end
                end
                LOCK: begin
                    pos <= pos_inc;
                    if (bnd) begin
                        bad_flag <= 1'b0;
                        // exit is deferred one frame so the last frame is never cut
                        if (exit_due) begin
                            state    <= HUNT;
                            lock_o   <= 1'b0;
                            pos      <= '0;
                            miss_cnt <= '0;
                        end else begin
                            chip_idx <= chip_inc;
                            if (!sop_i || bad_flag) begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end else begin
                                miss_cnt <= '0;
                            end
                        end
                    end else if (sop_i) begin
                        bad_flag <= 1'b1;
                    end
                end
                default: begin
                    state  <= HUNT;
                    lock_o <= 1'b0;
                    pos    <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || err_clr_i) begin
            err_cnt_o <= '0;
        end else if (miss_ev && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_o      <= 1'b0;
            sop_o      <= 1'b0;
            eop_o      <= 1'b0;
            dat_o      <= '0;
            chip_idx_o <= '0;
        end else begin
            vld_o <= payload;
            sop_o <= payload && (pos == PW'(HDR_LEN));
            eop_o <= payload && (pos == PW'(CHIP_LEN - 1));
            if (payload) begin
                dat_o      <= {dat7_i, dat6_i, dat5_i, dat4_i,
                               dat3_i, dat2_i, dat1_i, dat0_i};
                chip_idx_o <= chip_idx;
            end
        end
    end

endmodule

// File: doc/cpri_chip_sync_unpack.md
Name: cpri_chip_sync_unpack

Overview:
- Sits directly downstream of the CPRI PRB pattern/ROM generator.
- Consumes its sop pulse and eight 64-bit lane words, and acquires chip-frame alignment with a hunt/check/lock flywheel.
- Strips the per-chip header words and emits the payload as a 512-bit parallel stream with valid/sop/eop and a chip index. This stream feeds the PRB extraction / dimension-reduction stage.
- Also reports lock status and a saturating alignment-error count.

Parameters:
- CHIP_LEN, 96, words per chip frame (sop period in cycles); must be > HDR_LEN+1.
- HDR_LEN, 4, header words at frame start that are dropped.
- CHIP_COUNT, 36, chips per symbol group; range of chip_idx_o.
- DAT_DW, 64, width of each lane word.
- LOCK_CNT, 3, consecutive correctly spaced sops needed after the first one to enter LOCK.
- UNLOCK_CNT, 2, consecutive bad frame boundaries in LOCK that force a return to HUNT.
- ERR_DW, 16, width of the error counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- sop_i  in  1  marks word 0 of a chip frame; aligned with dat*_i
- dat0_i..dat7_i  in  DAT_DW each  lane words, one per cycle
- err_clr_i  in  1  synchronous clear of err_cnt_o
- vld_o  out  1  payload word valid
- sop_o  out  1  first payload word of a chip
- eop_o  out  1  last payload word of a chip
- dat_o  out  8*DAT_DW  {dat7..dat0}, lane 0 in the LSBs
- chip_idx_o  out  clog2(CHIP_COUNT)  chip index of the current word
- lock_o  out  1  state==LOCK
- err_cnt_o  out  ERR_DW  saturating count of boundary errors

Behaviour:
- Reset: state=HUNT, pos=0, good_cnt=0, miss_cnt=0, bad_flag=0.
- Reset: all outputs 0, including dat_o, err_cnt_o and chip_idx_o. A reset mid-frame aborts immediately; there is no trailing eop.
- pos tracks the index of the current input word. After alignment it increments every cycle and wraps CHIP_LEN-1→0. A "boundary" is a cycle with pos==0.
- HUNT:
  - sop_i=1 → CHECK, with pos=1 next cycle and good_cnt=0.
  - No outputs are produced in HUNT.
- CHECK:
  - At a boundary with sop_i=1: good_cnt+1. If good_cnt reaches LOCK_CNT, go to LOCK in that same cycle's next state and set chip_idx=0.
  - At a boundary with sop_i=0: go to HUNT.
  - sop_i=1 at pos≠0: realign, with pos=1 next cycle and good_cnt=0; stay in CHECK.
- LOCK (flywheel; pos is never realigned):
  - sop_i=1 at pos≠0 sets bad_flag.
  - At each boundary: if sop_i=0 or bad_flag=1, it is a miss. A miss increments miss_cnt and err_cnt (saturating at all-ones).
  - If miss_cnt reaches UNLOCK_CNT, go to HUNT after the boundary.
  - A good boundary clears miss_cnt.
  - bad_flag clears at every boundary.
  - State changes in LOCK happen only at boundaries, so output frames are never truncated.
- Output pipeline: fixed 1-cycle registered latency from the input word. For an input word with state==LOCK and pos≥HDR_LEN:
  - vld_o=1 and dat_o = the lane words.
  - sop_o=1 at pos==HDR_LEN.
  - eop_o=1 at pos==CHIP_LEN-1.
- Otherwise vld_o, sop_o and eop_o are 0. dat_o holds its last value.
- Payload is CHIP_LEN-HDR_LEN words per chip (92 by default).
- chip_idx:
  - Set to 0 on entry to LOCK.
  - In LOCK, increments at each subsequent boundary, wrapping CHIP_COUNT-1→0.
  - chip_idx_o is registered alongside dat_o.
- The frame whose boundary caused LOCK entry is output with chip_idx_o=0.
- Boundary at which LOCK exits: that frame is still output. On the following boundary the state is HUNT, so no further output.
- lock_o is the registered state==LOCK, with 1-cycle latency.
- err_cnt: err_clr_i has priority over an increment in the same cycle, giving 0. Errors are counted only in LOCK.

Test Plan:
- Clean stream, sop every 96 cycles from cycle 10:
  - lock_o rises 1 cycle after the 4th sop (cycle 298+1).
  - First sop_o at input pos 4 of that frame.
  - 92 vld_o per frame; eop_o at pos 95.
  - chip_idx_o runs 0,1,…,35,0.
  - err_cnt_o stays 0.
- Same stream with one sop dropped after lock: err_cnt_o=1, lock_o stays 1, output continues with no gap. The next good sop clears miss_cnt.
- Two consecutive sops dropped: err_cnt_o=2. The frame at the 2nd boundary is still output, then lock_o falls. The stream re-locks after 4 good sops.
- Spurious sop at pos 50 in LOCK, with the next boundary sop present: counted as a miss (err_cnt_o+1), and pos is not realigned. The payload of that frame is output intact.
- Misplaced sop in CHECK (after 2 good sops, a sop at pos 40): realign, so lock needs 3 further sops at the new phase.
- err_cnt_o forced to 16'hFFFF by repeated misses: it stays at FFFF. err_clr_i asserted together with a miss gives 0. rst mid-frame: all outputs 0 the next cycle and state HUNT.
